// File: rtl/fht_but_sched.sv
// Purpose : sequences one fht_but butterfly through every radix-2 stage of an N = 2^LOG_N point FHT.
// Latency : read strobes/addresses registered in the issue cycle t; x0 read at t+1; y0/y1 write at t+LAT.
// Backpressure: none; runs free once started, delay lines shift every cycle and never stall.
//
// Ports:
//   iCLK, iRESET (async, active low), iSTART (sampled in IDLE only)
//   oBUSY / oDONE      : RUN+DRAIN indicator / one-cycle completion pulse
//   oSTAGE / oBANK     : current stage s and read bank s[0] (write bank is ~s[0])
//   oRD_EN_12, oRD_ADDR_1, oRD_ADDR_2, oCOEF_ADDR : x1/x2 reads and twiddle index at issue
//   oRD_EN_0, oRD_ADDR_0                          : x0 read, one cycle after issue
//   oWR_EN, oWR_ADDR_0, oWR_ADDR_1                : y0/y1 write-back, LAT cycles after issue
module fht_but_sched #(
  parameter int LOG_N = 8,
  parameter int LAT   = 3
) (
  input  logic                       iCLK,
  input  logic                       iRESET,
  input  logic                       iSTART,
  output logic                       oBUSY,
  output logic                       oDONE,
  output logic [$clog2(LOG_N)-1:0]   oSTAGE,
  output logic                       oBANK,
  output logic                       oRD_EN_12,
  output logic [LOG_N-1:0]           oRD_ADDR_1,
  output logic [LOG_N-1:0]           oRD_ADDR_2,
  output logic [LOG_N-2:0]           oCOEF_ADDR,
  output logic                       oRD_EN_0,
  output logic [LOG_N-1:0]           oRD_ADDR_0,
  output logic                       oWR_EN,
  output logic [LOG_N-1:0]           oWR_ADDR_0,
  output logic [LOG_N-1:0]           oWR_ADDR_1
);

  localparam int SW = $clog2(LOG_N);
  localparam int BW = LOG_N - 1;
  localparam int DW = $clog2(LAT + 1);
  localparam logic [BW-1:0]    BMAX = '1;
  localparam logic [LOG_N-1:0] ONE  = LOG_N'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One slot of the write-back delay line.
  typedef struct packed {
    logic             en;
    logic [LOG_N-1:0] a0;
    logic [LOG_N-1:0] a1;
  } dl_t;

  state_t         state, state_nxt;
  logic [SW-1:0]  s, s_nxt;
  logic [BW-1:0]  b, b_nxt;
  logic [DW-1:0]  d, d_nxt;

  // Issue-stage values computed from the next (s, b) so they are registered
  // on the same edge that enters RUN for that butterfly.
  logic             issue_nxt;
  logic [LOG_N-1:0] bw, h, kmask, k, base;
  logic [LOG_N-1:0] a0_nxt, a1_nxt, a2_nxt;
  logic [BW-1:0]    coef_nxt;
  logic [31:0]      sh;

  logic             rd12_q;
  logic [LOG_N-1:0] a0_q, a1_q, a2_q;
  logic [BW-1:0]    coef_q;
  dl_t              pipe [LAT];

  // State register
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state <= IDLE;
      s     <= '0;
      b     <= '0;
      d     <= '0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      b     <= b_nxt;
      d     <= d_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    b_nxt     = b;
    d_nxt     = d;
    case (state)
      IDLE: begin
        if (iSTART) begin
          state_nxt = RUN;
          s_nxt     = '0;
          b_nxt     = '0;
        end
      end
      RUN: begin
        if (b == BMAX) begin
          state_nxt = DRAIN;
          d_nxt     = '0;
        end else begin
          b_nxt = b + BW'(1);
        end
      end
      DRAIN: begin
        if (d == DW'(LAT - 1)) begin
          if (s == SW'(LOG_N - 1)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
            s_nxt     = s + SW'(1);
            b_nxt     = '0;
          end
        end else begin
          d_nxt = d + DW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: butterfly addressing for the next issue slot.
  // Group base g*2h is b with its low s bits cleared, shifted up by one.
  always_comb begin
    issue_nxt = (state_nxt == RUN);
    bw        = {1'b0, b_nxt};
    h         = ONE << s_nxt;
    kmask     = h - ONE;
    k         = bw & kmask;
    base      = (bw & ~kmask) << 1;
    sh        = 32'(LOG_N - 1) - 32'(s_nxt);
    a0_nxt    = '0;
    a1_nxt    = '0;
    a2_nxt    = '0;
    coef_nxt  = '0;
    if (issue_nxt) begin
      a0_nxt   = base | k;
      a1_nxt   = base + h + k;
      // Mirror partner (h-k) mod h, so k=0 pairs with itself (addr2 = addr1).
      a2_nxt   = base + h + ((h - k) & kmask);
      // k < 2^s, so the shifted index always fits in LOG_N-1 bits.
      coef_nxt = k[BW-1:0] << sh;
    end
  end

  // Issue registers and the fixed-length delay line behind them.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      rd12_q <= 1'b0;
      a0_q   <= '0;
      a1_q   <= '0;
      a2_q   <= '0;
      coef_q <= '0;
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      rd12_q  <= issue_nxt;
      a0_q    <= a0_nxt;
      a1_q    <= a1_nxt;
      a2_q    <= a2_nxt;
      coef_q  <= coef_nxt;
      pipe[0] <= '{en: rd12_q, a0: a0_q, a1: a1_q};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign oBUSY      = (state == RUN) || (state == DRAIN);
  assign oDONE      = (state == DONE);
  assign oSTAGE     = s;
  assign oBANK      = s[0];
  assign oRD_EN_12  = rd12_q;
  assign oRD_ADDR_1 = a1_q;
  assign oRD_ADDR_2 = a2_q;
  assign oCOEF_ADDR = coef_q;
  assign oRD_EN_0   = pipe[0].en;
  assign oRD_ADDR_0 = pipe[0].a0;
  assign oWR_EN     = pipe[LAT-1].en;
  assign oWR_ADDR_0 = pipe[LAT-1].a0;
  assign oWR_ADDR_1 = pipe[LAT-1].a1;

endmodule

// File: tb/tb_fht_but_sched.sv
// Purpose : scoreboard bench for fht_but_sched (LOG_N=3, LAT=3) with a formula-level reference model.
// Latency : expectations are stamped with the cycle they must appear in.
// Backpressure: none; the monitor pops whenever the DUT raises a strobe.
module tb_fht_but_sched;

  localparam int LOG_N = 3;
  localparam int LAT   = 3;
  localparam int N     = 1 << LOG_N;
  localparam int HALF  = N / 2;
  localparam int P     = HALF + LAT;
  localparam int SW    = $clog2(LOG_N);

  logic             iCLK = 1'b0;
  logic             iRESET;
  logic             iSTART;
  logic             oBUSY, oDONE, oBANK;
  logic [SW-1:0]    oSTAGE;
  logic             oRD_EN_12, oRD_EN_0, oWR_EN;
  logic [LOG_N-1:0] oRD_ADDR_1, oRD_ADDR_2, oRD_ADDR_0, oWR_ADDR_0, oWR_ADDR_1;
  logic [LOG_N-2:0] oCOEF_ADDR;

  fht_but_sched #(.LOG_N(LOG_N), .LAT(LAT)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
    .oBUSY(oBUSY), .oDONE(oDONE), .oSTAGE(oSTAGE), .oBANK(oBANK),
    .oRD_EN_12(oRD_EN_12), .oRD_ADDR_1(oRD_ADDR_1), .oRD_ADDR_2(oRD_ADDR_2),
    .oCOEF_ADDR(oCOEF_ADDR), .oRD_EN_0(oRD_EN_0), .oRD_ADDR_0(oRD_ADDR_0),
    .oWR_EN(oWR_EN), .oWR_ADDR_0(oWR_ADDR_0), .oWR_ADDR_1(oWR_ADDR_1)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int a0;
    int a1;
    int a2;
    int coef;
  } ev_t;

  ev_t iss_q[$];
  ev_t rd0_q[$];
  ev_t wr_q[$];
  int  done_q[$];

  int checks = 0, errors = 0;
  int ready_cyc = 0, run_start = -100, run_end = -100;
  int done_seen = 0, accepts = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  function automatic int outs();
    return int'({oBUSY, oDONE, oSTAGE, oBANK, oRD_EN_12, oRD_ADDR_1, oRD_ADDR_2,
                 oCOEF_ADDR, oRD_EN_0, oRD_ADDR_0, oWR_EN, oWR_ADDR_0, oWR_ADDR_1});
  endfunction

  // Reference model: a start accepted while driving interval cyc begins RUN in
  // the next interval; every butterfly's events follow from plain arithmetic.
  task automatic accept();
    int  c0, h, g, k, t;
    ev_t e;
    c0 = cyc + 1;
    for (int s = 0; s < LOG_N; s++) begin
      h = 1 << s;
      for (int b = 0; b < HALF; b++) begin
        g      = b / h;
        k      = b % h;
        e.a0   = g * 2 * h + k;
        e.a1   = e.a0 + h;
        e.a2   = g * 2 * h + h + ((h - k) % h);
        e.coef = k * (N / (2 * h));
        t      = c0 + s * P + b;
        e.cyc  = t;       iss_q.push_back(e);
        e.cyc  = t + 1;   rd0_q.push_back(e);
        e.cyc  = t + LAT; wr_q.push_back(e);
      end
    end
    done_q.push_back(c0 + LOG_N * P);
    run_start = c0;
    run_end   = c0 + LOG_N * P - 1;
    ready_cyc = c0 + LOG_N * P + 1;
    accepts++;
  endtask

  task automatic step(input logic st);
    @(posedge iCLK);
    #1;
    iSTART = st;
    if (st && cyc >= ready_cyc) accept();
  endtask

  task automatic do_reset(input int hold);
    @(posedge iCLK);
    #3;
    iRESET = 1'b0;
    iSTART = 1'b0;
    iss_q.delete();
    rd0_q.delete();
    wr_q.delete();
    done_q.delete();
    run_start = -100;
    run_end   = -100;
    ready_cyc = 0;
    #1;
    chk("async_reset_outputs_zero", outs(), 0);
    repeat (hold) @(posedge iCLK);
    #3;
    iRESET = 1'b1;
  endtask

  // Monitor: decoupled from stimulus, samples on the falling edge.
  always @(negedge iCLK) begin
    ev_t e;
    int  busy_exp, stg;
    if (!iRESET) begin
      chk("reset_outputs_zero", outs(), 0);
    end else begin
      busy_exp = (cyc >= run_start && cyc <= run_end) ? 1 : 0;
      chk("busy", int'(oBUSY), busy_exp);
      if (busy_exp != 0) begin
        stg = (cyc - run_start) / P;
        chk("stage", int'(oSTAGE), stg);
        chk("bank", int'(oBANK), stg % 2);
      end
      if (oRD_EN_12) begin
        chk("issue_expected", int'(iss_q.size() > 0), 1);
        if (iss_q.size() > 0) begin
          e = iss_q.pop_front();
          chk("issue_cycle", cyc, e.cyc);
          chk("rd_addr_1", int'(oRD_ADDR_1), e.a1);
          chk("rd_addr_2", int'(oRD_ADDR_2), e.a2);
          chk("coef_addr", int'(oCOEF_ADDR), e.coef);
        end
      end
      if (oRD_EN_0) begin
        chk("rd0_expected", int'(rd0_q.size() > 0), 1);
        if (rd0_q.size() > 0) begin
          e = rd0_q.pop_front();
          chk("rd0_cycle", cyc, e.cyc);
          chk("rd_addr_0", int'(oRD_ADDR_0), e.a0);
        end
      end
      if (oWR_EN) begin
        chk("wr_expected", int'(wr_q.size() > 0), 1);
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr_0", int'(oWR_ADDR_0), e.a0);
          chk("wr_addr_1", int'(oWR_ADDR_1), e.a1);
        end
      end
      if (oDONE) begin
        done_seen++;
        chk("done_expected", int'(done_q.size() > 0), 1);
        if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  initial begin
    int d0, a0cnt;
    iRESET = 1'b0;
    iSTART = 1'b0;

    // Reset held over several clocks, released asynchronously mid-cycle.
    repeat (3) @(posedge iCLK);
    #3;
    chk("held_reset_outputs_zero", outs(), 0);
    iRESET = 1'b1;
    step(1'b0);
    step(1'b0);
    chk("idle_after_reset_busy", int'(oBUSY), 0);

    // Full run with stray start pulses at relative cycles 5 and 12.
    d0 = done_seen;
    step(1'b1);
    for (int i = 1; i <= 25; i++) step(i == 5 || i == 12);
    chk("done_count_single_run", done_seen - d0, 1);

    // Reset during stage 1 RUN; no write may escape from in-flight butterflies.
    step(1'b1);
    repeat (9) step(1'b0);
    do_reset(2);
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge iCLK);
      chk("no_wr_after_reset", int'(oWR_EN), 0);
    end
    d0 = done_seen;
    step(1'b1);
    repeat (25) step(1'b0);
    chk("done_count_after_reset", done_seen - d0, 1);

    // Start held high: back-to-back transforms.
    d0 = done_seen;
    a0cnt = accepts;
    repeat (2 * (LOG_N * P + 2)) step(1'b1);
    repeat (30) step(1'b0);
    chk("held_start_accepts", accepts - a0cnt, 2);
    chk("held_start_done_count", done_seen - d0, accepts - a0cnt);

    // Randomized start pulses with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(int'($urandom_range(1, 3)));
      else step($urandom_range(0, 7) == 0);
    end
    repeat (40) step(1'b0);

    chk("issue_queue_drained", iss_q.size(), 0);
    chk("rd0_queue_drained", rd0_q.size(), 0);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
